// File: rtl/hacd_csr_bank_pkg.sv
// Shared register offsets, CTRL layout and decode types for the HACD CSR bank.
package hacd_csr_bank_pkg;

  localparam int unsigned HACD_AW = 32;
  localparam int unsigned HACD_DW = 32;

  // Byte offsets of the global registers and of the per-channel window
  localparam logic [31:0] HACD_CTRL_OFF   = 32'h00;
  localparam logic [31:0] HACD_STATUS_OFF = 32'h04;
  localparam logic [31:0] HACD_MASK_OFF   = 32'h08;
  localparam logic [31:0] HACD_CMD_OFF    = 32'h0C;
  localparam logic [31:0] HACD_CH_BASE    = 32'h10;
  localparam logic [31:0] HACD_CH_STRIDE  = 32'h10;

  // High-watermark status/mask bits start here
  localparam int unsigned HACD_HIGH_BIT = 16;

  typedef struct packed {
    logic [29:0] rsvd;
    logic        irq_en;
    logic        mon_en;
  } hacd_ctrl_t;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_MASK,
    REG_CMD,
    REG_LOW,
    REG_HIGH,
    REG_FREE,
    REG_EVT
  } hacd_reg_e;

  // STATUS/MASK bits that physically exist for a given channel count
  function automatic logic [31:0] hacd_ch_bits(input int unsigned num_ch);
    logic [31:0] bits;
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(num_ch)) begin
        bits[i]                 = 1'b1;
        bits[HACD_HIGH_BIT + i] = 1'b1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/hacd_csr_bank_if.sv
// Register bus between the software master and the HACD CSR bank.
interface hacd_csr_bank_if;
  import hacd_csr_bank_pkg::*;

  logic               valid;
  logic               write;
  logic [HACD_AW-1:0] addr;
  logic [HACD_DW-1:0] wdata;
  logic               ready;
  logic [HACD_DW-1:0] rdata;
  logic               error;

  modport master (output valid, write, addr, wdata, input ready, rdata, error);
  modport slave  (input valid, write, addr, wdata, output ready, rdata, error);
endinterface

// File: rtl/hacd_csr_bank_wm_monitor.sv
// One free-page watermark channel: samples the count, detects threshold
// crossings and keeps a saturating count of low-watermark events.
module hacd_wm_monitor #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned EVT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_en,
  input  logic [CNT_W-1:0] free_in,
  input  logic [CNT_W-1:0] low_wm,
  input  logic [CNT_W-1:0] high_wm,
  input  logic             evt_clr,
  output logic [CNT_W-1:0] free_q,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             low_evt,
  output logic             high_evt
);

  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic below;
  logic above;
  logic below_q;
  logic above_q;

  assign below    = free_q < low_wm;
  assign above    = free_q > high_wm;
  // Only a fresh crossing is an event; a held condition stays silent
  assign low_evt  = mon_en & below & ~below_q;
  assign high_evt = mon_en & above & ~above_q;

  // Sample the free count and remember the previous condition flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q  <= '0;
      below_q <= 1'b0;
      above_q <= 1'b0;
    end else begin
      free_q  <= free_in;
      below_q <= mon_en & below;
      above_q <= mon_en & above;
    end
  end

  // Saturating low-event counter; a clear coinciding with an event leaves 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (evt_clr) begin
      evt_cnt <= EVT_W'(low_evt);
    end else if (low_evt && (evt_cnt != EVT_MAX)) begin
      evt_cnt <= evt_cnt + EVT_W'(1);
    end
  end

endmodule

// File: rtl/hacd_csr_bank.sv
// HACD control/status register bank: CTRL/STATUS/MASK/CMD plus per-channel
// watermark registers, watermark monitors and interrupt generation.
module hacd_csr_bank
  import hacd_csr_bank_pkg::*;
#(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned EVT_W      = 16,
  parameter logic [31:0] LOW_WM_RST = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  hacd_csr_bank_if.slave          bus,
  input  logic [NUM_CH*CNT_W-1:0] free_cnt_i,
  output logic [31:0]             hacd_ctrl_q,
  output logic                    infl_trig_o,
  output logic                    defl_trig_o,
  output logic                    infl_interrupt,
  output logic                    defl_interrupt
);

  localparam logic [31:0] CH_BITS  = hacd_ch_bits(NUM_CH);
  localparam int          CH_SHIFT = $clog2(HACD_CH_STRIDE);

  hacd_ctrl_t  ctrl_reg;
  logic [31:0] status_reg;
  logic [31:0] mask_reg;
  logic        infl_trig_reg;
  logic        defl_trig_reg;

  hacd_reg_e   sel;
  logic        dec_err;
  logic [31:0] ch_num;
  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] rdata_next;
  logic [31:0] hw_set;
  logic [31:0] w1c;

  logic [NUM_CH-1:0] low_evt;
  logic [NUM_CH-1:0] high_evt;
  logic [CNT_W-1:0]  low_wm_arr  [NUM_CH];
  logic [CNT_W-1:0]  high_wm_arr [NUM_CH];
  logic [CNT_W-1:0]  free_arr    [NUM_CH];
  logic [EVT_W-1:0]  evt_arr     [NUM_CH];

  assign ch_num = (bus.addr - HACD_CH_BASE) >> CH_SHIFT;

  // Address decode: register select plus every error condition
  always_comb begin
    sel     = REG_CTRL;
    dec_err = 1'b0;
    if (bus.addr[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else if (bus.addr < HACD_CH_BASE) begin
      case (bus.addr)
        HACD_CTRL_OFF:   sel = REG_CTRL;
        HACD_STATUS_OFF: sel = REG_STATUS;
        HACD_MASK_OFF:   sel = REG_MASK;
        HACD_CMD_OFF:    sel = REG_CMD;
        default:         dec_err = 1'b1;
      endcase
    end else begin
      case (bus.addr[3:2])
        2'd0:    sel = REG_LOW;
        2'd1:    sel = REG_HIGH;
        2'd2:    sel = REG_FREE;
        default: sel = REG_EVT;
      endcase
      if (ch_num >= 32'(NUM_CH)) dec_err = 1'b1;
    end
    if (bus.write && (sel == REG_FREE)) dec_err = 1'b1;
  end

  assign wr_ok = bus.valid &  bus.write & ~dec_err;
  assign rd_ok = bus.valid & ~bus.write & ~dec_err;

  // Combinational read mux; CMD and errored accesses return 0
  always_comb begin
    rdata_next = '0;
    if (rd_ok) begin
      case (sel)
        REG_CTRL:   rdata_next = ctrl_reg;
        REG_STATUS: rdata_next = status_reg;
        REG_MASK:   rdata_next = mask_reg;
        REG_CMD:    rdata_next = '0;
        default: begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_num == 32'(i)) begin
              case (sel)
                REG_LOW:  rdata_next = 32'(low_wm_arr[i]);
                REG_HIGH: rdata_next = 32'(high_wm_arr[i]);
                REG_FREE: rdata_next = 32'(free_arr[i]);
                default:  rdata_next = 32'(evt_arr[i]);
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.ready = 1'b1;
  assign bus.rdata = rdata_next;
  assign bus.error = bus.valid & dec_err;

  // Gather monitor events into the STATUS bit layout
  always_comb begin
    hw_set = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      hw_set[i]                 = low_evt[i];
      hw_set[HACD_HIGH_BIT + i] = high_evt[i];
    end
  end

  assign w1c = (wr_ok && (sel == REG_STATUS)) ? (bus.wdata & CH_BITS) : '0;

  // Global registers; hardware set beats a simultaneous W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_reg   <= '0;
      mask_reg   <= '0;
      status_reg <= '0;
    end else begin
      if (wr_ok && (sel == REG_CTRL)) ctrl_reg <= hacd_ctrl_t'(bus.wdata);
      if (wr_ok && (sel == REG_MASK)) mask_reg <= bus.wdata & CH_BITS;
      status_reg <= (status_reg & ~w1c) | hw_set;
    end
  end

  // Command pulses: high for exactly the cycle after the CMD write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_trig_reg <= 1'b0;
      defl_trig_reg <= 1'b0;
    end else begin
      infl_trig_reg <= wr_ok && (sel == REG_CMD) && bus.wdata[0];
      defl_trig_reg <= wr_ok && (sel == REG_CMD) && bus.wdata[1];
    end
  end

  generate
    for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
      logic             ch_hit;
      logic [CNT_W-1:0] low_wm_reg;
      logic [CNT_W-1:0] high_wm_reg;

      assign ch_hit = (ch_num == 32'(gi));

      // Per-channel watermark thresholds
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          low_wm_reg  <= LOW_WM_RST[CNT_W-1:0];
          high_wm_reg <= '1;
        end else if (wr_ok && ch_hit) begin
          if (sel == REG_LOW)  low_wm_reg  <= bus.wdata[CNT_W-1:0];
          if (sel == REG_HIGH) high_wm_reg <= bus.wdata[CNT_W-1:0];
        end
      end

      assign low_wm_arr[gi]  = low_wm_reg;
      assign high_wm_arr[gi] = high_wm_reg;

      hacd_wm_monitor #(
        .CNT_W (CNT_W),
        .EVT_W (EVT_W)
      ) u_mon (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .mon_en   (ctrl_reg.mon_en),
        .free_in  (free_cnt_i[gi*CNT_W +: CNT_W]),
        .low_wm   (low_wm_reg),
        .high_wm  (high_wm_reg),
        .evt_clr  (wr_ok && ch_hit && (sel == REG_EVT)),
        .free_q   (free_arr[gi]),
        .evt_cnt  (evt_arr[gi]),
        .low_evt  (low_evt[gi]),
        .high_evt (high_evt[gi])
      );
    end
  endgenerate

  assign hacd_ctrl_q    = ctrl_reg;
  assign infl_trig_o    = infl_trig_reg;
  assign defl_trig_o    = defl_trig_reg;
  assign infl_interrupt = ctrl_reg.irq_en &
                          |(status_reg[NUM_CH-1:0] & mask_reg[NUM_CH-1:0]);
  assign defl_interrupt = ctrl_reg.irq_en &
                          |(status_reg[HACD_HIGH_BIT +: NUM_CH] & mask_reg[HACD_HIGH_BIT +: NUM_CH]);

endmodule
